cpu_program_loader: RTL
=======================

Name: cpu_program_loader

Overview:
- Hardware boot/run controller on the driving side of the pipelined CPU.
- Accepts a word stream over a valid/ready handshake and writes it into instruction memory and then data memory.
- Once loading finishes, asserts the CPU start input for a bounded number of cycles, then reports completion.
- Replaces bench-side memory preloading and start sequencing, so the same program image can be driven from a host link.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- DMEM_BYTES, 32, data memory size in bytes; must be a multiple of 4.
- RUN_CYCLES, 30, number of cycles start is held high before the run ends.
- CNT_W, 16, width of the cycle and performance counters.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- s_valid_i  in  1  input word valid.
- s_data_i  in  32  input word (header or payload).
- s_ready_o  out  1  loader can accept a word this cycle.
- abort_i  in  1  return to IDLE immediately.
- imem_we_o  out  1  instruction memory write strobe.
- imem_addr_o  out  $clog2(IMEM_DEPTH)  instruction memory word index.
- dmem_we_o  out  1  data memory word write strobe (4 bytes, little-endian).
- dmem_addr_o  out  $clog2(DMEM_BYTES)  data memory byte address, always 4-aligned.
- mem_wdata_o  out  32  write data shared by both memories.
- cpu_start_o  out  1  drives the CPU start_i.
- stall_i  in  1  CPU hazard-unit stall indication (used only with PERF_CNT_EN).
- flush_i  in  1  CPU IF flush indication (used only with PERF_CNT_EN).
- cycle_cnt_o  out  CNT_W  number of cycles start has been high in the current run.
- done_o  out  1  run completed.
- err_o  out  1  header rejected.

Behaviour:
- Reset: while rst_n_i is low at a rising edge, state goes to IDLE. All outputs are 0 except s_ready_o, which is 1 in IDLE. Counters clear. Memory contents are not cleared; a reset during a load leaves partial contents.
- Handshake: a word is accepted on a cycle where s_valid_i and s_ready_o are both 1. s_ready_o is 1 only in IDLE, LD_IMEM and LD_DMEM, and 0 in any cycle where abort_i is 1.
- Header word: [15:0] NI = number of instruction words; [31:16] ND = number of data words.
  - NI > IMEM_DEPTH or ND > DMEM_BYTES/4 -> ERR.
  - Otherwise the next state is: LD_IMEM if NI != 0; else LD_DMEM if ND != 0; else RUN.
- LD_IMEM:
  - The k-th accepted word (k = 0..NI-1) produces imem_we_o=1, imem_addr_o=k and mem_wdata_o=word, registered one cycle after acceptance.
  - After word NI-1 is accepted, go to LD_DMEM (or RUN if ND = 0).
- LD_DMEM:
  - The k-th accepted word produces dmem_we_o=1, dmem_addr_o=4k and the word, one cycle after acceptance.
  - After the last word is accepted, go to RUN.
- Stalls: any number of idle cycles between words is allowed; the address advances only on acceptance.
- RUN:
  - cpu_start_o=1 from the first cycle in RUN, which coincides with the cycle of the final write strobe.
  - cycle_cnt_o increments every cycle cpu_start_o is 1.
  - When cycle_cnt_o reaches RUN_CYCLES: cpu_start_o drops the same cycle, state goes to DONE, and cycle_cnt_o holds at RUN_CYCLES.
- DONE: done_o=1. Stays until abort_i or reset. cycle_cnt_o and the perf counters hold.
- ERR: err_o=1. Stays until abort_i or reset. No memory writes occur.
- abort_i from any state:
  - Next state IDLE; cpu_start_o=0 next cycle; done_o and err_o clear.
  - Counters clear.
  - A pending registered write strobe still completes.
- Simultaneous events: abort_i together with s_valid_i -> abort wins and the word is not accepted. Reset overrides everything.
- Address wrap is impossible because counts are bounded by the header check.

Optional Feature:
- Macro: CPU_LOADER_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt_o and flush_cnt_o, each CNT_W wide.
  - Each increments, saturating, in RUN cycles where stall_i or flush_i respectively is 1.
  - Each clears on reset or abort and holds in DONE.
- Undefined: those ports are absent; stall_i and flush_i are ignored.

Decomposition:
- Shared package cpu_loader_pkg:
  - state enum {IDLE, LD_IMEM, LD_DMEM, RUN, DONE, ERR};
  - header field positions NI_LSB=0, NI_MSB=15, ND_LSB=16, ND_MSB=31.
- Sub-module loader_sat_counter (CNT_W, enable, clear, saturating). Instantiated for the cycle counter and for both perf counters.

Test Plan:
- Header NI=3, ND=2, then words A,B,C,D,E with valid held high -> imem writes at 0,1,2 (A,B,C) and dmem writes at byte addresses 0,4 (D,E), each one cycle after acceptance. cpu_start_o rises in the same cycle as the dmem write at address 4, falls after 30 cycles; done_o=1, cycle_cnt_o=30.
- Header NI=0, ND=0 -> RUN the next cycle with no write strobes; done_o after 30 cycles.
- Header NI=257 -> err_o=1, s_ready_o=0, no writes; abort_i -> IDLE, err_o=0, s_ready_o=1.
- Header NI=4, then abort_i asserted with s_valid_i in the cycle of the 2nd payload word -> only the imem write at index 0 occurs; state IDLE; cpu_start_o never rises.
- rst_n_i low in cycle 10 of RUN -> next cycle cpu_start_o=0, cycle_cnt_o=0, s_ready_o=1.
- With CPU_LOADER_PERF_CNT_EN: stall_i high for 5 RUN cycles and flush_i high for 2 -> stall_cnt_o=5, flush_cnt_o=2, both held in DONE.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared types for the CPU program loader: FSM state encoding and header layout.
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_IMEM,
        LD_DMEM,
        RUN,
        DONE,
        ERR
    } state_e;

    localparam int unsigned NI_LSB = 0;
    localparam int unsigned NI_MSB = 15;
    localparam int unsigned ND_LSB = 16;
    localparam int unsigned ND_MSB = 31;

    // First phase still owed data; a header with NI=ND=0 goes straight to RUN.
    function automatic state_e next_load_state(input logic [15:0] ni, input logic [15:0] nd);
        if (ni != 16'd0) begin
            return LD_IMEM;
        end else if (nd != 16'd0) begin
            return LD_DMEM;
        end else begin
            return RUN;
        end
    endfunction

endpackage

// File: rtl/loader_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the run and perf counters.
module loader_sat_counter
    import cpu_loader_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_program_loader.sv
// Streams a header plus program/data words into IMEM/DMEM, then pulses CPU start.
// Optional perf counters (stall_cnt_o, flush_cnt_o) under CPU_LOADER_PERF_CNT_EN.
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter  int unsigned IMEM_DEPTH = 256,
    parameter  int unsigned DMEM_BYTES = 32,
    parameter  int unsigned RUN_CYCLES = 30,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned IA_W       = $clog2(IMEM_DEPTH),
    localparam int unsigned DA_W       = $clog2(DMEM_BYTES)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             s_valid_i,
    input  logic [31:0]      s_data_i,
    output logic             s_ready_o,
    input  logic             abort_i,
    output logic             imem_we_o,
    output logic [IA_W-1:0]  imem_addr_o,
    output logic             dmem_we_o,
    output logic [DA_W-1:0]  dmem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             cpu_start_o,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic             done_o,
    output logic             err_o
`ifdef CPU_LOADER_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    state_e            state_q;
    logic [15:0]       ni_q;
    logic [15:0]       nd_q;
    logic [15:0]       idx_q;
    logic              imem_we_q;
    logic              dmem_we_q;
    logic [IA_W-1:0]   imem_addr_q;
    logic [DA_W-1:0]   dmem_addr_q;
    logic [31:0]       wdata_q;
    logic              cpu_start_q;
    logic              done_q;
    logic              err_q;

    logic              ready;
    logic              accept;
    logic [15:0]       hdr_ni;
    logic [15:0]       hdr_nd;
    logic              hdr_bad;
    logic              last_word;
    logic              run_last;
    state_e            hdr_next;
    state_e            imem_next;

    always_comb begin
        ready     = ((state_q == IDLE) || (state_q == LD_IMEM) || (state_q == LD_DMEM)) && !abort_i;
        accept    = ready && s_valid_i;
        hdr_ni    = s_data_i[NI_MSB:NI_LSB];
        hdr_nd    = s_data_i[ND_MSB:ND_LSB];
        hdr_bad   = (32'(hdr_ni) > IMEM_DEPTH) || (32'(hdr_nd) > (DMEM_BYTES / 4));
        hdr_next  = next_load_state(hdr_ni, hdr_nd);
        imem_next = next_load_state(16'd0, nd_q);
        last_word = (state_q == LD_IMEM) ? (idx_q == ni_q - 16'd1) : (idx_q == nd_q - 16'd1);
        // Compare one short of the limit so start drops on the edge the count reaches it.
        run_last  = (cycle_cnt_o == CNT_W'(RUN_CYCLES - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ni_q        <= '0;
            nd_q        <= '0;
            idx_q       <= '0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            wdata_q     <= '0;
            cpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            if (abort_i) begin
                state_q     <= IDLE;
                idx_q       <= '0;
                cpu_start_q <= 1'b0;
                done_q      <= 1'b0;
                err_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            ni_q  <= hdr_ni;
                            nd_q  <= hdr_nd;
                            idx_q <= '0;
                            if (hdr_bad) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q     <= hdr_next;
                                cpu_start_q <= (hdr_next == RUN);
                            end
                        end
                    end
                    LD_IMEM: begin
                        if (accept) begin
                            imem_we_q   <= 1'b1;
                            imem_addr_q <= idx_q[IA_W-1:0];
                            wdata_q     <= s_data_i;
                            if (last_word) begin
                                idx_q       <= '0;
                                state_q     <= imem_next;
                                cpu_start_q <= (imem_next == RUN);
                            end else begin
                                idx_q <= idx_q + 16'd1;
                            end
                        end
                    end
                    LD_DMEM: begin
                        if (accept) begin
                            dmem_we_q   <= 1'b1;
                            dmem_addr_q <= {idx_q[DA_W-3:0], 2'b00};
                            wdata_q     <= s_data_i;
                            if (last_word) begin
                                idx_q       <= '0;
                                state_q     <= RUN;
                                cpu_start_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 16'd1;
                            end
                        end
                    end
                    RUN: begin
                        if (run_last) begin
                            state_q     <= DONE;
                            cpu_start_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                    DONE, ERR: begin
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    loader_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (abort_i),
        .en_i    (cpu_start_q),
        .cnt_o   (cycle_cnt_o)
    );

`ifdef CPU_LOADER_PERF_CNT_EN
    loader_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (abort_i),
        .en_i    (cpu_start_q && stall_i),
        .cnt_o   (stall_cnt_o)
    );

    loader_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (abort_i),
        .en_i    (cpu_start_q && flush_i),
        .cnt_o   (flush_cnt_o)
    );
`else
    logic unused_perf_in;
    assign unused_perf_in = stall_i ^ flush_i;
`endif

    assign s_ready_o   = ready;
    assign imem_we_o   = imem_we_q;
    assign imem_addr_o = imem_addr_q;
    assign dmem_we_o   = dmem_we_q;
    assign dmem_addr_o = dmem_addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_start_o = cpu_start_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
